// File: rtl/core_ahb_pkg.sv
// Shared AHB-Lite encodings for the core load/store bridge.
package core_ahb_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_NONSEQ = 2'b10
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000
  } hburst_e;

endpackage

// File: rtl/core_ahb_size_dec.sv
// Byte-enable to AHB size / low-address decoder for 32- or 64-bit data paths.
module core_ahb_size_dec #(
  parameter int BW_HDATA = 32
) (
  input  logic [BW_HDATA/8-1:0]         be,
  output logic [2:0]                    hsize,
  output logic [$clog2(BW_HDATA/8)-1:0] offset
);
  import core_ahb_pkg::*;

  localparam int NB   = BW_HDATA / 8;
  localparam int OFFW = $clog2(NB);

  logic [NB-1:0] be_eff;

  // Offset is always the lowest set lane; aligned groups start at that lane too.
  always_comb begin
    be_eff = (be == '0) ? '1 : be;
    hsize  = HSIZE_BYTE;
    offset = '0;
    for (int unsigned i = NB; i > 0; i--) begin
      if (be_eff[i-1]) offset = OFFW'(i - 1);
    end
    for (int unsigned k = 0; k < NB / 2; k++) begin
      if (be_eff == (NB'(2'b11) << (2 * k))) hsize = HSIZE_HALF;
    end
    for (int unsigned k = 0; k < NB / 4; k++) begin
      if (be_eff == (NB'(4'hF) << (4 * k))) hsize = HSIZE_WORD;
    end
    if (be_eff == '1) begin
      hsize  = (NB == 8) ? HSIZE_DWORD : HSIZE_WORD;
      offset = '0;
    end
  end

endmodule

// File: rtl/core_ahb_master.sv
// Pipelined core req/gnt/rvalid to AHB-Lite master bridge (AP/DP slots).
// Optional slave ERROR reporting: define CORE_AHB_MASTER_ERR_EN.
module core_ahb_master #(
  parameter int         BW_HADDR  = 32,
  parameter int         BW_HDATA  = 32,
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  data_req,
  output logic                  data_gnt,
  input  logic                  data_we,
  input  logic [BW_HDATA/8-1:0] data_be,
  input  logic [BW_HADDR-1:0]   data_addr,
  input  logic [BW_HDATA-1:0]   data_wdata,
  output logic                  data_rvalid,
  output logic [BW_HDATA-1:0]   data_rdata,
  output logic                  data_err,
  output logic [1:0]            ahb_htrans,
  output logic                  ahb_hsel,
  output logic                  ahb_hready,
  output logic                  ahb_hwrite,
  output logic [BW_HADDR-1:0]   ahb_haddr,
  output logic [2:0]            ahb_hsize,
  output logic [2:0]            ahb_hburst,
  output logic [3:0]            ahb_hprot,
  output logic                  ahb_hmastlock,
  output logic [BW_HDATA-1:0]   ahb_hwdata,
  input  logic                  ahb_hreadyout,
  input  logic                  ahb_hresp,
  input  logic [BW_HDATA-1:0]   ahb_hrdata
);
  import core_ahb_pkg::*;

  localparam int NB   = BW_HDATA / 8;
  localparam int OFFW = $clog2(NB);

  logic                ap_vld, ap_we;
  logic [BW_HADDR-1:0] ap_addr;
  logic [2:0]          ap_size;
  logic [BW_HDATA-1:0] ap_wdata;
  logic                dp_vld;
  logic [BW_HDATA-1:0] dp_wdata;

  logic                cancel, accept, advance;
  logic [2:0]          dec_size;
  logic [OFFW-1:0]     dec_off;
  logic [BW_HADDR-1:0] req_addr;

  core_ahb_size_dec #(.BW_HDATA(BW_HDATA)) u_size_dec (
    .be     (data_be),
    .hsize  (dec_size),
    .offset (dec_off)
  );

  assign req_addr = (data_addr & ~BW_HADDR'(NB - 1)) | BW_HADDR'(dec_off);

`ifdef CORE_AHB_MASTER_ERR_EN
  // One-cycle cancel after the first ERROR cycle drops the pending AP to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cancel <= 1'b0;
    else        cancel <= dp_vld & ~ahb_hreadyout & ahb_hresp & ~cancel;
  end
  assign data_err = data_rvalid & ahb_hresp;
`else
  assign cancel   = 1'b0;
  // cancel is tied low, so this is constant 0.
  assign data_err = cancel & ahb_hresp;
`endif

  assign data_gnt = ~ap_vld | (ahb_hreadyout & ~cancel);
  assign accept   = data_req & data_gnt;
  assign advance  = ahb_hreadyout & ~cancel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ap_vld   <= 1'b0;
      ap_we    <= 1'b0;
      ap_addr  <= '0;
      ap_size  <= '0;
      ap_wdata <= '0;
      dp_vld   <= 1'b0;
      dp_wdata <= '0;
    end else begin
      // The cancelled cycle retires DP (the errored transfer) but keeps AP.
      if (advance) begin
        dp_vld   <= ap_vld;
        dp_wdata <= ap_wdata;
      end else if (cancel && ahb_hreadyout) begin
        dp_vld   <= 1'b0;
      end
      if (accept) begin
        ap_vld   <= 1'b1;
        ap_we    <= data_we;
        ap_addr  <= req_addr;
        ap_size  <= dec_size;
        ap_wdata <= data_wdata;
      end else if (advance) begin
        ap_vld   <= 1'b0;
      end
    end
  end

  assign ahb_htrans    = (ap_vld & ~cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb_hsel      = ahb_htrans[1];
  assign ahb_hready    = ahb_hreadyout;
  assign ahb_hwrite    = ap_we;
  assign ahb_haddr     = ap_addr;
  assign ahb_hsize     = ap_size;
  assign ahb_hburst    = HBURST_SINGLE;
  assign ahb_hprot     = HPROT_VAL;
  assign ahb_hmastlock = 1'b0;
  assign ahb_hwdata    = dp_wdata;
  assign data_rvalid   = dp_vld & ahb_hreadyout;
  assign data_rdata    = ahb_hrdata;

endmodule

// File: tb/tb_core_ahb_master.sv
// Directed bench for core_ahb_master (32-bit instance plus a 64-bit decode instance).
module tb_core_ahb_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req, data_gnt, data_we, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [1:0]  ahb_htrans;
  logic        ahb_hsel, ahb_hready, ahb_hwrite, ahb_hmastlock;
  logic [31:0] ahb_haddr, ahb_hwdata, ahb_hrdata;
  logic [2:0]  ahb_hsize, ahb_hburst;
  logic [3:0]  ahb_hprot;
  logic        ahb_hreadyout, ahb_hresp;

  logic        w_req, w_gnt, w_we, w_rvalid, w_err;
  logic [7:0]  w_be;
  logic [31:0] w_addr, w_haddr;
  logic [63:0] w_wdata, w_rdata, w_hwdata;
  logic [1:0]  w_htrans;
  logic        w_hsel, w_hready, w_hwrite, w_hmastlock;
  logic [2:0]  w_hsize, w_hburst;
  logic [3:0]  w_hprot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_ahb_master dut (
    .clk(clk), .rst_n(rst_n), .data_req(data_req), .data_gnt(data_gnt), .data_we(data_we),
    .data_be(data_be), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata), .data_err(data_err),
    .ahb_htrans(ahb_htrans), .ahb_hsel(ahb_hsel), .ahb_hready(ahb_hready),
    .ahb_hwrite(ahb_hwrite), .ahb_haddr(ahb_haddr), .ahb_hsize(ahb_hsize),
    .ahb_hburst(ahb_hburst), .ahb_hprot(ahb_hprot), .ahb_hmastlock(ahb_hmastlock),
    .ahb_hwdata(ahb_hwdata), .ahb_hreadyout(ahb_hreadyout), .ahb_hresp(ahb_hresp),
    .ahb_hrdata(ahb_hrdata)
  );

  core_ahb_master #(.BW_HADDR(32), .BW_HDATA(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .data_req(w_req), .data_gnt(w_gnt), .data_we(w_we),
    .data_be(w_be), .data_addr(w_addr), .data_wdata(w_wdata),
    .data_rvalid(w_rvalid), .data_rdata(w_rdata), .data_err(w_err),
    .ahb_htrans(w_htrans), .ahb_hsel(w_hsel), .ahb_hready(w_hready),
    .ahb_hwrite(w_hwrite), .ahb_haddr(w_haddr), .ahb_hsize(w_hsize),
    .ahb_hburst(w_hburst), .ahb_hprot(w_hprot), .ahb_hmastlock(w_hmastlock),
    .ahb_hwdata(w_hwdata), .ahb_hreadyout(1'b1), .ahb_hresp(1'b0),
    .ahb_hrdata(64'h0)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
  } vec_t;

  typedef struct {
    logic [7:0]  be;
    logic [31:0] exp_haddr;
    logic [2:0]  exp_hsize;
  } vec64_t;

  vec_t   vecs[9];
  vec64_t v64[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
    data_req   = 1'b1;
    data_we    = we;
    data_be    = be;
    data_addr  = addr;
    data_wdata = wdata;
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'hF, 32'h100, 32'h0,      32'hDEADBEEF, 32'h100, 3'd2};
    vecs[1] = '{1'b0, 4'hC, 32'h20,  32'h0,      32'h12345678, 32'h22,  3'd1};
    vecs[2] = '{1'b0, 4'h4, 32'h40,  32'h0,      32'hCAFEF00D, 32'h42,  3'd0};
    vecs[3] = '{1'b1, 4'h0, 32'h0,   32'h600DF00D, 32'h0,      32'h0,   3'd2};
    vecs[4] = '{1'b0, 4'h3, 32'h10,  32'h0,      32'h0BADC0DE, 32'h10,  3'd1};
    vecs[5] = '{1'b1, 4'hA, 32'h30,  32'hAABBCCDD, 32'h0,      32'h31,  3'd0};
    vecs[6] = '{1'b0, 4'h8, 32'h50,  32'h0,      32'h87654321, 32'h53,  3'd0};
    vecs[7] = '{1'b0, 4'h6, 32'h60,  32'h0,      32'h13579BDF, 32'h61,  3'd0};
    vecs[8] = '{1'b0, 4'hF, 32'h103, 32'h0,      32'h2468ACE0, 32'h100, 3'd2};

    v64[0] = '{8'hFF, 32'h1000, 3'd3};
    v64[1] = '{8'hF0, 32'h1004, 3'd2};
    v64[2] = '{8'h0F, 32'h1000, 3'd2};
    v64[3] = '{8'h30, 32'h1004, 3'd1};
    v64[4] = '{8'h40, 32'h1006, 3'd0};
    v64[5] = '{8'h3C, 32'h1002, 3'd0};

    rst_n = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    ahb_hreadyout = 1'b1; ahb_hresp = 1'b0; ahb_hrdata = '0;
    w_req = 1'b0; w_we = 1'b0; w_be = '0; w_addr = '0; w_wdata = '0;
    #12;
    check("rst_htrans", 64'(ahb_htrans), 64'h0);
    check("rst_hsel",   64'(ahb_hsel),   64'h0);
    check("rst_haddr",  64'(ahb_haddr),  64'h0);
    check("rst_hwdata", 64'(ahb_hwdata), 64'h0);
    check("rst_rvalid", 64'(data_rvalid), 64'h0);
    check("rst_gnt",    64'(data_gnt),   64'h1);
    check("hprot",      64'(ahb_hprot),  64'h3);
    check("hburst",     64'(ahb_hburst), 64'h0);
    rst_n = 1'b1;
    tick();

    // Single transfers from the vector table, zero-wait slave.
    for (int i = 0; i < 9; i++) begin
      drive_req(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata);
      ahb_hrdata = vecs[i].rdata;
      check("v_gnt", 64'(data_gnt), 64'h1);
      tick();
      data_req = 1'b0;
      check("v_htrans", 64'(ahb_htrans), 64'h2);
      check("v_hsel",   64'(ahb_hsel),   64'h1);
      check("v_haddr",  64'(ahb_haddr),  64'(vecs[i].exp_haddr));
      check("v_hsize",  64'(ahb_hsize),  64'(vecs[i].exp_hsize));
      check("v_hwrite", 64'(ahb_hwrite), 64'(vecs[i].we));
      check("v_rv_early", 64'(data_rvalid), 64'h0);
      tick();
      check("v_rvalid", 64'(data_rvalid), 64'h1);
      check("v_err",    64'(data_err),    64'h0);
      if (vecs[i].we) check("v_hwdata", 64'(ahb_hwdata), 64'(vecs[i].wdata));
      else            check("v_rdata",  64'(data_rdata), 64'(vecs[i].rdata));
      tick();
      check("v_idle", 64'(ahb_htrans), 64'h0);
    end

    // Back-to-back writes overlap address and data phases.
    drive_req(1'b1, 4'hF, 32'h0, 32'h11);
    check("bb_gnt0", 64'(data_gnt), 64'h1);
    tick();
    check("bb_haddr0", 64'(ahb_haddr), 64'h0);
    drive_req(1'b1, 4'hF, 32'h4, 32'h22);
    check("bb_gnt1", 64'(data_gnt), 64'h1);
    tick();
    data_req = 1'b0;
    check("bb_haddr1", 64'(ahb_haddr),  64'h4);
    check("bb_hwdata0", 64'(ahb_hwdata), 64'h11);
    check("bb_rvalid0", 64'(data_rvalid), 64'h1);
    check("bb_htrans1", 64'(ahb_htrans), 64'h2);
    tick();
    check("bb_hwdata1", 64'(ahb_hwdata), 64'h22);
    check("bb_rvalid1", 64'(data_rvalid), 64'h1);
    check("bb_idle", 64'(ahb_htrans), 64'h0);
    tick();

    // Wait states on the data phase of 0x200 while 0x204 sits in AP.
    drive_req(1'b0, 4'hF, 32'h200, 32'hA5A5A5A5);
    tick();
    drive_req(1'b0, 4'hF, 32'h204, 32'h5A5A5A5A);
    tick();
    data_req = 1'b0;
    ahb_hreadyout = 1'b0;
    ahb_hrdata = 32'h0000C0DE;
    #1;
    check("ws_gnt", 64'(data_gnt), 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_htrans", 64'(ahb_htrans),  64'h2);
      check("ws_haddr",  64'(ahb_haddr),   64'h204);
      check("ws_hwdata", 64'(ahb_hwdata),  64'hA5A5A5A5);
      check("ws_rvalid", 64'(data_rvalid), 64'h0);
      check("ws_gnt_hold", 64'(data_gnt),  64'h0);
    end
    ahb_hreadyout = 1'b1;
    #1;
    check("ws_rvalid_a", 64'(data_rvalid), 64'h1);
    check("ws_rdata",    64'(data_rdata),  64'h0000C0DE);
    tick();
    check("ws_rvalid_b", 64'(data_rvalid), 64'h1);
    check("ws_hwdata_b", 64'(ahb_hwdata),  64'h5A5A5A5A);
    check("ws_idle",     64'(ahb_htrans),  64'h0);
    tick();
    check("ws_rvalid_end", 64'(data_rvalid), 64'h0);

`ifdef CORE_AHB_MASTER_ERR_EN
    // Slave ERROR on A while B waits in AP.
    drive_req(1'b0, 4'hF, 32'h400, 32'h0);
    tick();
    drive_req(1'b0, 4'hF, 32'h404, 32'h0);
    tick();
    data_req = 1'b0;
    ahb_hreadyout = 1'b0;
    ahb_hresp = 1'b1;
    #1;
    check("er_htrans_first", 64'(ahb_htrans), 64'h2);
    check("er_rvalid_first", 64'(data_rvalid), 64'h0);
    tick();
    ahb_hreadyout = 1'b1;
    #1;
    check("er_cancel_idle", 64'(ahb_htrans), 64'h0);
    check("er_cancel_gnt",  64'(data_gnt),   64'h0);
    check("er_rvalid_a",    64'(data_rvalid), 64'h1);
    check("er_err_a",       64'(data_err),   64'h1);
    tick();
    ahb_hresp = 1'b0;
    #1;
    check("er_reissue", 64'(ahb_htrans), 64'h2);
    check("er_haddr_b", 64'(ahb_haddr),  64'h404);
    check("er_no_rv",   64'(data_rvalid), 64'h0);
    tick();
    check("er_rvalid_b", 64'(data_rvalid), 64'h1);
    check("er_err_b",    64'(data_err),    64'h0);
    tick();
`endif

    // Reset in the middle of a wait state.
    drive_req(1'b1, 4'h3, 32'h300, 32'h77);
    tick();
    data_req = 1'b0;
    tick();
    ahb_hreadyout = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    ahb_hreadyout = 1'b1;
    #1;
    check("mr_htrans", 64'(ahb_htrans), 64'h0);
    check("mr_haddr",  64'(ahb_haddr),  64'h0);
    check("mr_hsize",  64'(ahb_hsize),  64'h0);
    check("mr_hwrite", 64'(ahb_hwrite), 64'h0);
    check("mr_hwdata", 64'(ahb_hwdata), 64'h0);
    check("mr_rvalid", 64'(data_rvalid), 64'h0);
    check("mr_gnt",    64'(data_gnt),   64'h1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_no_rvalid", 64'(data_rvalid), 64'h0);
    end

    // 64-bit data path size/offset decode.
    for (int i = 0; i < 6; i++) begin
      w_req = 1'b1;
      w_be = v64[i].be;
      w_addr = 32'h1000;
      tick();
      w_req = 1'b0;
      check("w_htrans", 64'(w_htrans), 64'h2);
      check("w_haddr",  64'(w_haddr),  64'(v64[i].exp_haddr));
      check("w_hsize",  64'(w_hsize),  64'(v64[i].exp_hsize));
      tick();
      check("w_rvalid", 64'(w_rvalid), 64'h1);
    end
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_ahb_master.md
Name: core_ahb_master

Overview:
- Pipelined, parametrised bridge from the core load/store port (req/gnt/rvalid) to a single AHB-Lite master port.
- Registers the address phase, so a new address phase overlaps the previous transfer's data phase. Back-to-back zero-wait transfers sustain one per cycle.
- Generalised over address and data width. Derives hsize and low address bits from the byte enables. Optionally reports slave ERROR responses to the core.
- Sits between the core LSU and the system AHB matrix.

Parameters:
- BW_HADDR, 32, address width.
- BW_HDATA, 32, data width; 32 or 64 only.
- HPROT_VAL, 4'b0011, constant driven on ahb_hprot (data, privileged).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- data_req  in  1  core request.
- data_gnt  out  1  request accepted this cycle.
- data_we  in  1  1 = write.
- data_be  in  BW_HDATA/8  byte enables.
- data_addr  in  BW_HADDR  byte address.
- data_wdata  in  BW_HDATA  write data.
- data_rvalid  out  1  transfer completed, in order, one per granted request.
- data_rdata  out  BW_HDATA  read data, equal to ahb_hrdata, valid with data_rvalid.
- data_err  out  1  completion had ERROR response (only with CORE_AHB_MASTER_ERR_EN).
- ahb_htrans  out  2  IDLE 2'b00 / NONSEQ 2'b10.
- ahb_hsel  out  1  equals ahb_htrans[1].
- ahb_hready  out  1  equals ahb_hreadyout.
- ahb_hwrite  out  1  write flag.
- ahb_haddr  out  BW_HADDR  address.
- ahb_hsize  out  3  size code.
- ahb_hburst  out  3  constant 3'b000 (SINGLE).
- ahb_hprot  out  4  constant HPROT_VAL.
- ahb_hmastlock  out  1  constant 0.
- ahb_hwdata  out  BW_HDATA  write data.
- ahb_hreadyout  in  1  slave ready.
- ahb_hresp  in  1  slave error.
- ahb_hrdata  in  BW_HDATA  read data.

Behaviour:
- Two stage slots: AP (address phase) and DP (data phase). Each slot holds valid, addr, we, size and wdata.
- Reset:
  - AP and DP valid = 0, all slot fields 0.
  - Outputs: htrans = IDLE, hsel = 0, hwrite = 0, haddr = 0, hsize = 0, hwdata = 0, data_rvalid = 0, data_err = 0.
  - data_gnt = 1, since it is combinational and AP is empty.
- Grant: data_gnt = ~ap_vld | (ahb_hreadyout & ~cancel). Accepting a request (data_req & data_gnt) loads AP on the next edge.
- Advance: on ahb_hreadyout = 1 and no cancel:
  - DP <= AP.
  - AP <= new request if one is accepted, else AP becomes invalid.
- ahb_hreadyout = 0: AP and DP hold; the AHB outputs stay stable.
- AHB drive from AP:
  - htrans = NONSEQ when ap_vld & ~cancel, else IDLE.
  - haddr, hwrite and hsize come from AP.
  - hwdata comes from DP.
- Completion: data_rvalid = dp_vld & ahb_hreadyout.
- Latency (zero-wait slave): request granted at cycle T, address phase T+1, data phase and rvalid at T+2.
- Size decode:
  - All be set: hsize = log2(BW_HDATA/8).
  - Aligned contiguous 4-byte group (64-bit only): hsize = 2.
  - Aligned pair: hsize = 1.
  - Any other pattern: hsize = 0.
  - haddr low bits = byte offset of the lowest set be bit. Upper bits come from data_addr.
- data_be = 0: treated as all ones.
- Non-contiguous be patterns: issued as a byte access at the lowest set lane; the other lanes are ignored.

Optional Feature:
- Macro: CORE_AHB_MASTER_ERR_EN.
- With the macro:
  - First ERROR cycle (dp_vld & ~hreadyout & hresp) sets `cancel` for one cycle.
  - While `cancel` is set, htrans = IDLE and data_gnt = 0. AP is retained and reissued as NONSEQ after `cancel` clears.
  - Second ERROR cycle gives data_rvalid = 1 with data_err = 1.
- Without the macro: ahb_hresp is ignored, data_err is absent, and `cancel` is constant 0.

Decomposition:
- Shared package core_ahb_pkg holds:
  - HTRANS_IDLE and HTRANS_NONSEQ.
  - HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD and HSIZE_DWORD.
  - HBURST_SINGLE.
- One natural sub-module: core_ahb_size_dec, a combinational be -> (hsize, addr offset) decoder parametrised by BW_HDATA.

Test Plan:
- Single read at 0x100, be = 4'hF, zero wait:
  - htrans = 2'b10, haddr = 0x100 and hsize = 2 at T+1.
  - data_rvalid = 1 at T+2, data_rdata = 0xDEADBEEF.
- Back-to-back writes to 0x0 and 0x4 with data 0x11, 0x22, hreadyout held high:
  - data_gnt stays 1 throughout.
  - Overlapped phases: hwdata = 0x11 in the same cycle haddr = 0x4.
- Read with hreadyout held low for 3 cycles:
  - haddr, htrans and hwdata stay stable.
  - data_gnt = 0 once AP is full.
  - data_rvalid pulses exactly once.
- be = 4'b1100, addr 0x20 -> haddr = 0x22, hsize = 1.
- be = 4'b0100 -> haddr offset 2, hsize = 0.
- With BW_HDATA = 64, be = 8'hF0 -> hsize = 2, offset 4.
- ERR_EN build, slave gives ERROR on transfer A while B sits in AP:
  - htrans = IDLE in the cancel cycle.
  - data_err = 1 with data_rvalid for A.
  - B is reissued the following cycle and completes with data_err = 0.
- rst_n asserted mid-wait-state:
  - All outputs return to reset values immediately.
  - No rvalid for the in-flight transfer after release.
